// File: rtl/tb_mem_arbiter.sv
// tb_mem_arbiter: shares one RAM port between two requesters.
//   Requester 0 is the core data port, requester 1 the stimulus/loader master.
//   Round-robin arbitration with a combinational single-cycle grant. The RAM
//   has a fixed 1-cycle read latency; one response stage routes each answer
//   back to the requester that owns the accepted transaction. Addresses
//   beyond the RAM are still granted but never reach the RAM, and they are
//   answered with an error response.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   mX_req_i / mX_gnt_o   request / same-cycle grant (X = 0, 1)
//   mX_addr_i, mX_we_i, mX_be_i, mX_wdata_i   request fields
//   mX_rvalid_o, mX_rdata_o, mX_err_o         response (err qualified by rvalid)
//   ram_req_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o   RAM command
//   ram_rdata_i           RAM read data, valid the cycle after ram_req_o
module tb_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 22
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      m0_req_i,
    output logic                      m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]     m0_addr_i,
    input  logic                      m0_we_i,
    input  logic [DATA_WIDTH/8-1:0]   m0_be_i,
    input  logic [DATA_WIDTH-1:0]     m0_wdata_i,
    output logic                      m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]     m0_rdata_o,
    output logic                      m0_err_o,

    input  logic                      m1_req_i,
    output logic                      m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]     m1_addr_i,
    input  logic                      m1_we_i,
    input  logic [DATA_WIDTH/8-1:0]   m1_be_i,
    input  logic [DATA_WIDTH-1:0]     m1_wdata_i,
    output logic                      m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]     m1_rdata_o,
    output logic                      m1_err_o,

    output logic                      ram_req_o,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
    output logic                      ram_we_o,
    output logic [DATA_WIDTH/8-1:0]   ram_be_o,
    output logic [DATA_WIDTH-1:0]     ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]     ram_rdata_i
);

    logic last_q, last_d;
    logic rsp_valid_q, rsp_valid_d;
    logic rsp_id_q, rsp_id_d;
    logic rsp_err_q, rsp_err_d;
    // Set only for in-range reads: the one case where RAM data is passed on.
    logic rsp_rd_q, rsp_rd_d;

    logic                  accept;
    logic                  sel;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_we;
    logic                  rsp_live;

    always_comb begin
        // Under contention the requester that was not served last wins.
        m0_gnt_o = !rst_i && m0_req_i && (!m1_req_i || last_q);
        m1_gnt_o = !rst_i && m1_req_i && (!m0_req_i || !last_q);
        accept   = m0_gnt_o || m1_gnt_o;
        sel      = m1_gnt_o;

        sel_addr = sel ? m1_addr_i : m0_addr_i;
        sel_we   = sel ? m1_we_i   : m0_we_i;
        in_range = (sel_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH] == '0);

        ram_req_o   = accept && in_range;
        ram_addr_o  = sel_addr[RAM_ADDR_WIDTH-1:0];
        ram_we_o    = sel_we;
        ram_be_o    = sel ? m1_be_i    : m0_be_i;
        ram_wdata_o = sel ? m1_wdata_i : m0_wdata_i;

        last_d      = accept ? sel : last_q;
        rsp_valid_d = accept;
        rsp_id_d    = sel;
        rsp_err_d   = accept && !in_range;
        rsp_rd_d    = accept && in_range && !sel_we;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rd_q    <= 1'b0;
        end else begin
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rd_q    <= rsp_rd_d;
        end
    end

    // Reset in the response cycle kills the pending answer immediately.
    assign rsp_live    = rsp_valid_q && !rst_i;

    assign m0_rvalid_o = rsp_live && !rsp_id_q;
    assign m1_rvalid_o = rsp_live &&  rsp_id_q;
    assign m0_err_o    = m0_rvalid_o && rsp_err_q;
    assign m1_err_o    = m1_rvalid_o && rsp_err_q;
    assign m0_rdata_o  = (m0_rvalid_o && rsp_rd_q) ? ram_rdata_i : '0;
    assign m1_rdata_o  = (m1_rvalid_o && rsp_rd_q) ? ram_rdata_i : '0;

endmodule

// File: tb/tb_tb_mem_arbiter.sv
// Self-checking bench for tb_mem_arbiter: directed scenarios followed by
// random traffic, compared against a transaction-level reference model.
module tb_tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0, r1, w0, w1;
    logic [31:0] a0, a1, d0, d1;
    logic [3:0]  be0, be1;
    logic        g0, g1, rv0, rv1, er0, er1;
    logic [31:0] rd0, rd1;
    logic        ram_req, ram_we;
    logic [21:0] ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata, ram_rdata;
    logic        ram_clr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tb_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_ADDR_WIDTH(22)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(r0), .m0_gnt_o(g0), .m0_addr_i(a0), .m0_we_i(w0),
        .m0_be_i(be0), .m0_wdata_i(d0), .m0_rvalid_o(rv0), .m0_rdata_o(rd0),
        .m0_err_o(er0),
        .m1_req_i(r1), .m1_gnt_o(g1), .m1_addr_i(a1), .m1_we_i(w1),
        .m1_be_i(be1), .m1_wdata_i(d1), .m1_rvalid_o(rv1), .m1_rdata_o(rd1),
        .m1_err_o(er1),
        .ram_req_o(ram_req), .ram_addr_o(ram_addr), .ram_we_o(ram_we),
        .ram_be_o(ram_be), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    // RAM environment: 1 KiW, 1-cycle read latency, junk data when not reading.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
            ram_rdata <= '0;
        end else if (ram_req && !ram_we) begin
            ram_rdata <= mem[ram_addr[11:2]];
        end else begin
            if (ram_req)
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr[11:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            ram_rdata <= $urandom;
        end
    end

    // Reference model: memory image, last-served requester, pending response.
    logic [31:0] ref_mem [0:1023];
    int          exp_last;
    bit          pend_v;
    int          pend_id;
    bit          pend_err;
    logic [31:0] pend_data;
    bit          exp_g0, exp_g1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle();
        int          win;
        logic [31:0] addr, wd;
        logic [3:0]  be;
        bit          we, inr;
        win = -1;
        if (!rst) begin
            if (r0 && r1) win = (exp_last == 0) ? 1 : 0;
            else if (r0)  win = 0;
            else if (r1)  win = 1;
        end
        exp_g0 = (win == 0);
        exp_g1 = (win == 1);
        addr = (win == 1) ? a1  : a0;
        we   = (win == 1) ? w1  : w0;
        be   = (win == 1) ? be1 : be0;
        wd   = (win == 1) ? d1  : d0;
        inr  = (addr < 32'h0040_0000);

        chk("gnt0", g0, exp_g0);
        chk("gnt1", g1, exp_g1);
        chk("ram_req", ram_req, (win >= 0) && inr);
        if (win >= 0 && inr) begin
            chk("ram_addr", ram_addr, addr[21:0]);
            chk("ram_we", ram_we, we);
            chk("ram_be", ram_be, be);
            chk("ram_wdata", ram_wdata, wd);
        end
        chk("rvalid0", rv0, pend_v && !rst && pend_id == 0);
        chk("rvalid1", rv1, pend_v && !rst && pend_id == 1);
        chk("err0", er0, pend_v && !rst && pend_id == 0 && pend_err);
        chk("err1", er1, pend_v && !rst && pend_id == 1 && pend_err);
        chk("rdata0", rd0, (pend_v && !rst && pend_id == 0) ? pend_data : 32'h0);
        chk("rdata1", rd1, (pend_v && !rst && pend_id == 1) ? pend_data : 32'h0);

        if (rst) begin
            exp_last = 1;
            pend_v   = 0;
        end else if (win >= 0) begin
            exp_last  = win;
            pend_v    = 1;
            pend_id   = win;
            pend_err  = !inr;
            pend_data = (inr && !we) ? ref_mem[addr[11:2]] : 32'h0;
            if (inr && we)
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[addr[11:2]][b*8 +: 8] = wd[b*8 +: 8];
        end else begin
            pend_v = 0;
        end
    endtask

    task automatic sample();
        #3;
        check_cycle();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic rq, input logic [31:0] ad, input logic we,
                        input logic [3:0] be, input logic [31:0] wd);
        r0 = rq; a0 = ad; w0 = we; be0 = be; d0 = wd;
    endtask

    task automatic drv1(input logic rq, input logic [31:0] ad, input logic we,
                        input logic [3:0] be, input logic [31:0] wd);
        r1 = rq; a1 = ad; w1 = we; be1 = be; d1 = wd;
    endtask

    initial begin
        bit          hold0, hold1;
        logic [31:0] pre_addr [0:4];
        logic [31:0] pre_data [0:4];
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        exp_last = 1;
        pend_v = 0; pend_id = 0; pend_err = 0; pend_data = '0;
        ram_clr = 1'b1;
        rst = 1'b1;
        drv0(1'b1, 32'h0, 1'b0, 4'hF, 32'h0);
        drv1(1'b1, 32'h4, 1'b0, 4'hF, 32'h0);
        adv();

        // Requests held high during reset must not be granted.
        for (int k = 0; k < 2; k++) begin
            sample();
            chk("rst_gnt0", g0, 1'b0);
            chk("rst_ram_req", ram_req, 1'b0);
            adv();
        end
        ram_clr = 1'b0;
        rst = 1'b0;
        drv0(1'b0, 32'h0, 1'b0, 4'hF, 32'h0);

        // Preload through the loader master.
        pre_addr[0] = 32'h100; pre_data[0] = 32'hA5A5_0001;
        pre_addr[1] = 32'h040; pre_data[1] = 32'hCAFE_BABE;
        pre_addr[2] = 32'h000; pre_data[2] = 32'h1111_1111;
        pre_addr[3] = 32'h004; pre_data[3] = 32'h2222_2222;
        pre_addr[4] = 32'h008; pre_data[4] = 32'h3333_3333;
        for (int k = 0; k < 5; k++) begin
            drv1(1'b1, pre_addr[k], 1'b1, 4'hF, pre_data[k]);
            sample();
            adv();
        end
        drv1(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);

        // Lone m0 read of 0x100.
        drv0(1'b1, 32'h100, 1'b0, 4'hF, 32'h0);
        sample();
        chk("t1_gnt0", g0, 1'b1);
        chk("t1_ram_req", ram_req, 1'b1);
        chk("t1_ram_addr", ram_addr, 22'h100);
        adv();
        drv0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        sample();
        chk("t1_rvalid0", rv0, 1'b1);
        chk("t1_rdata0", rd0, 32'hA5A5_0001);
        chk("t1_err0", er0, 1'b0);
        chk("t1_rvalid1", rv1, 1'b0);
        adv();

        // Fresh reset, then four cycles of contention.
        rst = 1'b1;
        sample();
        adv();
        rst = 1'b0;
        drv0(1'b1, 32'h100, 1'b0, 4'hF, 32'h0);
        drv1(1'b1, 32'h040, 1'b0, 4'hF, 32'h0);
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("rr_gnt0", g0, (k % 2) == 0);
            chk("rr_gnt1", g1, (k % 2) == 1);
            if (k > 0) chk("rr_rvalid0", rv0, ((k - 1) % 2) == 0);
            adv();
        end
        drv0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        drv1(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        sample();
        chk("rr_last_rvalid1", rv1, 1'b1);
        chk("rr_last_rdata1", rd1, 32'hCAFE_BABE);
        adv();

        // Partial write by m1, then read back by m0.
        drv1(1'b1, 32'h40, 1'b1, 4'b0011, 32'h1234_5678);
        sample();
        chk("wr_ram_we", ram_we, 1'b1);
        chk("wr_ram_be", ram_be, 4'b0011);
        chk("wr_ram_wdata", ram_wdata, 32'h1234_5678);
        adv();
        drv1(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        sample();
        chk("wr_rvalid1", rv1, 1'b1);
        chk("wr_err1", er1, 1'b0);
        chk("wr_rvalid0", rv0, 1'b0);
        adv();
        drv0(1'b1, 32'h40, 1'b0, 4'hF, 32'h0);
        sample();
        adv();
        drv0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        sample();
        chk("merge_rdata0", rd0, 32'hCAFE_5678);
        adv();

        // Out-of-range read.
        drv0(1'b1, 32'h0040_0000, 1'b0, 4'hF, 32'h0);
        sample();
        chk("oor_gnt0", g0, 1'b1);
        chk("oor_ram_req", ram_req, 1'b0);
        adv();
        drv0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        sample();
        chk("oor_rvalid0", rv0, 1'b1);
        chk("oor_err0", er0, 1'b1);
        chk("oor_rdata0", rd0, 32'h0);
        adv();

        // Reset right after an m1 accept drops its response.
        drv1(1'b1, 32'h100, 1'b0, 4'hF, 32'h0);
        sample();
        adv();
        drv1(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        rst = 1'b1;
        sample();
        chk("rstmid_rvalid1", rv1, 1'b0);
        adv();
        rst = 1'b0;
        drv0(1'b1, 32'h4, 1'b0, 4'hF, 32'h0);
        drv1(1'b1, 32'h8, 1'b0, 4'hF, 32'h0);
        sample();
        chk("rstmid_gnt0", g0, 1'b1);
        chk("rstmid_gnt1", g1, 1'b0);
        adv();
        drv0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        drv1(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        sample();
        adv();

        // Streaming m0 reads with no bubbles.
        for (int k = 0; k < 3; k++) begin
            drv0(1'b1, 32'(k * 4), 1'b0, 4'hF, 32'h0);
            sample();
            chk("str_gnt0", g0, 1'b1);
            if (k > 0) begin
                chk("str_rvalid0", rv0, 1'b1);
                chk("str_rdata0", rd0, pre_data[k + 1]);
            end
            adv();
        end
        drv0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        sample();
        chk("str_rvalid0_last", rv0, 1'b1);
        chk("str_rdata0_last", rd0, 32'h3333_3333);
        adv();

        // Random traffic; an ungranted requester keeps its request unchanged.
        hold0 = 0;
        hold1 = 0;
        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            if (!hold0)
                drv0($urandom_range(0, 3) != 0,
                     ($urandom_range(0, 9) == 0) ? (32'h0040_0000 | $urandom)
                                                 : 32'($urandom_range(0, 1023) * 4),
                     $urandom_range(0, 1) == 1, 4'($urandom), $urandom);
            if (!hold1)
                drv1($urandom_range(0, 3) != 0,
                     ($urandom_range(0, 9) == 0) ? (32'h8000_0000 | $urandom)
                                                 : 32'($urandom_range(0, 1023) * 4),
                     $urandom_range(0, 1) == 1, 4'($urandom), $urandom);
            sample();
            hold0 = r0 && !exp_g0;
            hold1 = r1 && !exp_g1;
            adv();
        end
        rst = 1'b0;
        drv0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        drv1(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        sample();
        adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
